// File: rtl/afu_pkg.sv
// Shared AFU command-path types: command buffer line, arbiter policy select
// and the idle line value driven when the arbiter output slot is empty.
package AFU_PKG;

  typedef enum logic {
    ARB_FIXED       = 1'b0,
    ARB_ROUND_ROBIN = 1'b1
  } ArbiterMode;

  typedef enum logic [3:0] {
    INVALID    = 4'd0,
    READ_CL_NA = 4'd1,
    READ_CL_S  = 4'd2,
    WRITE_NI   = 4'd3,
    WRITE_MI   = 4'd4
  } CommandType;

  typedef enum logic [1:0] {
    STRICT = 2'd0,
    ABORT  = 2'd1,
    PAGE   = 2'd2,
    SPEC   = 2'd3
  } TraceAbort;

  typedef struct packed {
    logic        valid;
    logic [7:0]  cmd;
    CommandType  command;
    logic [63:0] address;
    logic [11:0] size;
    TraceAbort   abt;
  } CommandBufferLine;

  localparam CommandBufferLine COMMAND_BUFFER_LINE_IDLE = '{
    valid:   1'b0,
    cmd:     8'h00,
    command: INVALID,
    address: 64'h0,
    size:    12'h0,
    abt:     STRICT
  };

endpackage

// File: rtl/command_buffer_arbiter_rr_round_robin_priority_arbiter.sv
// Combinational priority pick: lowest index in fixed mode, first requester at
// or after ptr (wrapping) in round-robin mode.
import AFU_PKG::*;

module round_robin_priority_arbiter #(
  parameter int NUM_REQUESTS = 4
) (
  input  logic [NUM_REQUESTS-1:0]         reqs,
  input  logic [$clog2(NUM_REQUESTS)-1:0] ptr,
  input  ArbiterMode                      mode,
  output logic [NUM_REQUESTS-1:0]         grants,
  output logic [$clog2(NUM_REQUESTS)-1:0] grant_index
);

  localparam int PTR_W = $clog2(NUM_REQUESTS);

  logic [PTR_W-1:0] start;
  logic             found;
  int               idx;

  always_comb begin
    grants      = '0;
    grant_index = '0;
    found       = 1'b0;
    idx         = 0;
    start       = (mode == ARB_ROUND_ROBIN) ? ptr : '0;
    for (int i = 0; i < NUM_REQUESTS; i++) begin
      idx = int'(start) + i;
      if (idx >= NUM_REQUESTS) idx = idx - NUM_REQUESTS;
      if (!found && reqs[idx]) begin
        found       = 1'b1;
        grants[idx] = 1'b1;
        grant_index = PTR_W'(idx);
      end
    end
  end

endmodule

// File: rtl/command_buffer_arbiter_rr.sv
// Merges per-engine command buffers into one registered command stream with
// selectable round-robin/fixed policy, grant lock and downstream back-pressure.
// Optional per-requester grant counters when ARB_GRANT_STATS_EN is defined.
import AFU_PKG::*;

module command_buffer_arbiter_rr #(
  parameter int NUM_REQUESTS = 4,
  parameter int PTR_W        = $clog2(NUM_REQUESTS)
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               enabled_in,
  input  ArbiterMode                         arb_mode,
  input  logic [NUM_REQUESTS-1:0]            lock_in,
  input  CommandBufferLine [NUM_REQUESTS-1:0] command_buffer_in,
  input  logic [NUM_REQUESTS-1:0]            requests,
  output logic [NUM_REQUESTS-1:0]            ready,
  output CommandBufferLine                   command_arbiter_out,
  input  logic                               out_ready
`ifdef ARB_GRANT_STATS_EN
  , output logic [31:0]                      grant_count [NUM_REQUESTS]
`endif
);

  logic             enabled_q;
  ArbiterMode       mode_q, mode_eff;
  logic             mode_chg;
  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d, ptr_eff;
  logic             lock_vld_q, lock_vld_d, lock_hit;
  logic [PTR_W-1:0] lock_idx_q, lock_idx_d;
  CommandBufferLine out_q, out_d;

  logic                    free, arb_en;
  logic [NUM_REQUESTS-1:0] arb_grants;
  logic [PTR_W-1:0]        arb_index, grant_idx;

  // Policy may only switch while nothing is parked in the output slot.
  assign mode_eff = out_q.valid ? mode_q : arb_mode;
  assign mode_chg = (mode_eff != mode_q);
  assign ptr_eff  = mode_chg ? '0 : rr_ptr_q;

  round_robin_priority_arbiter #(
    .NUM_REQUESTS(NUM_REQUESTS)
  ) u_pick (
    .reqs       (requests),
    .ptr        (ptr_eff),
    .mode       (mode_eff),
    .grants     (arb_grants),
    .grant_index(arb_index)
  );

  always_comb begin
    free       = ~out_q.valid | out_ready;
    arb_en     = enabled_q & free;
    lock_hit   = lock_vld_q & lock_in[lock_idx_q] & requests[lock_idx_q];
    ready      = '0;
    grant_idx  = arb_index;
    rr_ptr_d   = ptr_eff;
    lock_vld_d = lock_vld_q;
    lock_idx_d = lock_idx_q;
    out_d      = out_q;

    if (arb_en) begin
      if (lock_hit) begin
        ready[lock_idx_q] = 1'b1;
        grant_idx         = lock_idx_q;
      end else begin
        ready = arb_grants;
        if (|arb_grants)
          rr_ptr_d = (arb_index == PTR_W'(NUM_REQUESTS - 1)) ? '0 : arb_index + PTR_W'(1);
      end
      lock_vld_d = |ready;
      lock_idx_d = grant_idx;
    end else if (lock_vld_q && !requests[lock_idx_q]) begin
      lock_vld_d = 1'b0;
    end

    if (|ready) begin
      out_d       = command_buffer_in[grant_idx];
      out_d.valid = 1'b1;
    end else if (out_ready) begin
      out_d = COMMAND_BUFFER_LINE_IDLE;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      enabled_q  <= 1'b0;
      mode_q     <= ARB_FIXED;
      rr_ptr_q   <= '0;
      lock_vld_q <= 1'b0;
      lock_idx_q <= '0;
      out_q      <= COMMAND_BUFFER_LINE_IDLE;
    end else begin
      enabled_q  <= enabled_in;
      mode_q     <= mode_eff;
      rr_ptr_q   <= rr_ptr_d;
      lock_vld_q <= lock_vld_d;
      lock_idx_q <= lock_idx_d;
      out_q      <= out_d;
    end
  end

  assign command_arbiter_out = out_q;

`ifdef ARB_GRANT_STATS_EN
  logic [31:0] cnt_q [NUM_REQUESTS];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < NUM_REQUESTS; k++) cnt_q[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_REQUESTS; k++)
        if (ready[k] && cnt_q[k] != 32'hFFFF_FFFF) cnt_q[k] <= cnt_q[k] + 32'd1;
    end
  end

  assign grant_count = cnt_q;
`endif

endmodule

// File: tb/tb_command_buffer_arbiter_rr.sv
// Scoreboard bench for command_buffer_arbiter_rr: a behavioural model predicts
// each cycle's grant, queues the expected line and compares it one cycle later.
module tb_command_buffer_arbiter_rr;
  import AFU_PKG::*;

  localparam int N = 4;

  logic                     clock = 1'b0;
  logic                     reset;
  logic                     enabled_in;
  logic                     out_ready;
  ArbiterMode               arb_mode;
  logic [N-1:0]             lock_in;
  logic [N-1:0]             requests;
  logic [N-1:0]             ready;
  CommandBufferLine [N-1:0] command_buffer_in;
  CommandBufferLine         command_arbiter_out;
`ifdef ARB_GRANT_STATS_EN
  logic [31:0]              grant_count [N];
  int unsigned              m_cnt [N];
`endif

  int n_checks = 0;
  int n_errors = 0;

  CommandBufferLine exp_q[$];
  CommandBufferLine m_out;
  logic             m_en, m_valid, m_lock_v;
  int               m_ptr, m_lock_idx;
  ArbiterMode       m_mode;

  command_buffer_arbiter_rr #(.NUM_REQUESTS(N)) dut (
    .clock              (clock),
    .reset              (reset),
    .enabled_in         (enabled_in),
    .arb_mode           (arb_mode),
    .lock_in            (lock_in),
    .command_buffer_in  (command_buffer_in),
    .requests           (requests),
    .ready              (ready),
    .command_arbiter_out(command_arbiter_out),
    .out_ready          (out_ready)
`ifdef ARB_GRANT_STATS_EN
    , .grant_count      (grant_count)
`endif
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_en       = 1'b0;
    m_valid    = 1'b0;
    m_lock_v   = 1'b0;
    m_lock_idx = 0;
    m_ptr      = 0;
    m_mode     = ARB_FIXED;
    m_out      = COMMAND_BUFFER_LINE_IDLE;
    exp_q.delete();
`ifdef ARB_GRANT_STATS_EN
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
`endif
  endtask

  // Called at posedge+1; leaves at posedge+1 with reset released.
  task automatic do_reset();
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    model_reset();
    check("reset_out", command_arbiter_out, COMMAND_BUFFER_LINE_IDLE);
  endtask

  // One clock cycle: called at posedge+1 with control inputs already driven.
  task automatic cycle();
    logic [N-1:0]     exp_rdy;
    int               k;
    int               idx;
    int               ptr_eff;
    bit               free, arb, locked;
    ArbiterMode       mode_eff;
    CommandBufferLine l;

    for (int i = 0; i < N; i++) begin
      command_buffer_in[i].valid   = 1'($urandom_range(0, 1));
      command_buffer_in[i].cmd     = 8'($urandom);
      command_buffer_in[i].command = CommandType'(4'($urandom_range(1, 4)));
      command_buffer_in[i].address = {$urandom, $urandom};
      command_buffer_in[i].size    = 12'($urandom);
      command_buffer_in[i].abt     = TraceAbort'(2'($urandom_range(0, 3)));
    end
    #3;

    free     = !m_valid || out_ready;
    arb      = m_en && free;
    mode_eff = m_valid ? m_mode : arb_mode;
    ptr_eff  = (mode_eff != m_mode) ? 0 : m_ptr;
    k        = -1;
    locked   = 1'b0;
    if (arb) begin
      if (m_lock_v && lock_in[m_lock_idx] && requests[m_lock_idx]) begin
        k      = m_lock_idx;
        locked = 1'b1;
      end else begin
        for (int j = 0; j < N; j++) begin
          idx = (mode_eff == ARB_ROUND_ROBIN) ? (ptr_eff + j) % N : j;
          if (k < 0 && requests[idx]) k = idx;
        end
      end
    end
    exp_rdy = '0;
    if (k >= 0) exp_rdy[k] = 1'b1;
    check("ready", ready, exp_rdy);

    if (k >= 0) begin
      l       = command_buffer_in[k];
      l.valid = 1'b1;
      exp_q.push_back(l);
    end
    m_ptr = (k >= 0 && !locked) ? (k + 1) % N : ptr_eff;
    if (arb) begin
      m_lock_v = (k >= 0);
      if (k >= 0) m_lock_idx = k;
    end else if (m_lock_v && !requests[m_lock_idx]) begin
      m_lock_v = 1'b0;
    end
    m_mode = mode_eff;
    m_en   = enabled_in;
`ifdef ARB_GRANT_STATS_EN
    if (k >= 0 && m_cnt[k] != 32'hFFFF_FFFF) m_cnt[k]++;
`endif

    @(posedge clock);
    #1;
    if (k >= 0) begin
      m_out   = exp_q.pop_front();
      m_valid = 1'b1;
    end else if (out_ready) begin
      m_out   = COMMAND_BUFFER_LINE_IDLE;
      m_valid = 1'b0;
    end
    check("out_line", command_arbiter_out, m_out);
  endtask

  initial begin
    reset             = 1'b1;
    enabled_in        = 1'b0;
    arb_mode          = ARB_FIXED;
    lock_in           = '0;
    requests          = '0;
    out_ready         = 1'b1;
    command_buffer_in = '0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    do_reset();

    // fixed priority, 1010 -> requester 1 every cycle
    enabled_in = 1'b1;
    requests   = 4'b1010;
    repeat (6) cycle();

    // drain, switch to round-robin, full load
    requests = '0;
    arb_mode = ARB_ROUND_ROBIN;
    repeat (2) cycle();
    requests = 4'b1111;
    repeat (8) cycle();

    // back-pressure then release with no bubble
    out_ready = 1'b0;
    repeat (5) cycle();
    out_ready = 1'b1;
    repeat (3) cycle();

    // lock: put pointer at 1, then 2,2,2 locked, then 0, then pointer at 1
    requests = '0;
    cycle();
    requests = 4'b0001;
    cycle();
    requests = 4'b0101;
    lock_in  = 4'b0100;
    repeat (3) cycle();
    lock_in = '0;
    cycle();
    requests = 4'b1111;
    cycle();

    // random traffic, back-pressure, enable and mode toggling
    repeat (80) begin
      requests  = 4'($urandom);
      lock_in   = 4'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) == 0) enabled_in = ~enabled_in;
      if ($urandom_range(0, 7) == 0)
        arb_mode = (arb_mode == ARB_FIXED) ? ARB_ROUND_ROBIN : ARB_FIXED;
      cycle();
    end

    // reset mid-stream with the output valid
    enabled_in = 1'b1;
    out_ready  = 1'b1;
    arb_mode   = ARB_ROUND_ROBIN;
    requests   = 4'b1111;
    lock_in    = '0;
    repeat (2) cycle();
    check("pre_reset_valid", command_arbiter_out.valid, 1'b1);
    do_reset();
    repeat (3) cycle();

`ifdef ARB_GRANT_STATS_EN
    do_reset();
    requests = 4'b1000;
    repeat (11) cycle();
    check("grant_count3", grant_count[3], 32'd10);
    for (int i = 0; i < N; i++) check("grant_count", grant_count[i], m_cnt[i]);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
